iterative_shift_unit: RTL and testbench

//  Multi-cycle barrel-shift replacement for the datapath shift stage. Consumes the
//  5-bit effective shift amount selected upstream (rt, shamt or MDR[4:0]) plus a
//  32-bit operand. Shifts one bit position per clock under a start/done handshake.

---
 rtl/iterative_shift_unit.sv | 95 +++++++++
 tb/tb_iterative_shift_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/iterative_shift_unit.sv
// Iterative shifter: applies one 1-bit SLL/SRL/SRA/ROR step per clock under a start/done handshake.
// A shift amount of N takes N+1 cycles from the accepting edge to the done pulse.
module iterative_shift_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int AMT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            shift_op,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [AMT_WIDTH-1:0]  shift_amount,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [AMT_WIDTH-1:0]  shiftCount_q, shiftCount_d;
    logic [1:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] stepValue;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            result_q     <= '0;
            shiftCount_q <= '0;
            op_q         <= OP_SLL;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            shiftCount_q <= shiftCount_d;
            op_q         <= op_d;
        end
    end

    always_comb begin
        stepValue = result_q;
        case (op_q)
            OP_SLL:  stepValue = {result_q[DATA_WIDTH-2:0], 1'b0};
            OP_SRL:  stepValue = {1'b0, result_q[DATA_WIDTH-1:1]};
            OP_SRA:  stepValue = {result_q[DATA_WIDTH-1], result_q[DATA_WIDTH-1:1]};
            OP_ROR:  stepValue = {result_q[0], result_q[DATA_WIDTH-1:1]};
            default: stepValue = result_q;
        endcase
    end

    // Operand, amount and op are captured only in IDLE, so later input changes are ignored.
    always_comb begin
        state_d      = state_q;
        result_d     = result_q;
        shiftCount_d = shiftCount_q;
        op_d         = op_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    result_d     = data_in;
                    shiftCount_d = shift_amount;
                    op_d         = shift_op;
                    state_d      = (shift_amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                result_d     = stepValue;
                shiftCount_d = shiftCount_q - AMT_WIDTH'(1);
                if (shiftCount_q == AMT_WIDTH'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign result = result_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_iterative_shift_unit.sv
// Directed self-checking bench for iterative_shift_unit; inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_iterative_shift_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  shift_op;
    logic [31:0] data_in;
    logic [4:0]  shift_amount;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    iterative_shift_unit #(
        .DATA_WIDTH(32),
        .AMT_WIDTH (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .shift_op    (shift_op),
        .data_in     (data_in),
        .shift_amount(shift_amount),
        .result      (result),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] data, input logic [4:0] amt);
        @(negedge clk);
        shift_op     = op;
        data_in      = data;
        shift_amount = amt;
        start        = 1'b1;
    endtask

    // Launches one operation, scrambles the inputs after acceptance, and checks latency, result and pulse shape.
    task automatic runOp(input string tag, input logic [1:0] op, input logic [31:0] data,
                         input logic [4:0] amt, input logic [31:0] expResult);
        int cycles;
        bit seen;
        applyStimulus(op, data, amt);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 40) begin
            @(posedge clk);
            cycles++;
            #1;
            start        = 1'b0;
            data_in      = ~data;
            shift_op     = ~op;
            shift_amount = ~amt;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checkOutput({tag, "_doneSeen"}, 32'(seen), 32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles), 32'(amt) + 32'd1);
        checkOutput({tag, "_result"}, result, expResult);
        checkOutput({tag, "_busyInDone"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({tag, "_donePulse"}, 32'(done), 32'd0);
        checkOutput({tag, "_busyAfter"}, 32'(busy), 32'd0);
        checkOutput({tag, "_resultHold"}, result, expResult);
    endtask

    initial begin
        int doneCount;
        int doneCycle;
        reset        = 1'b1;
        start        = 1'b0;
        shift_op     = 2'b00;
        data_in      = '0;
        shift_amount = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_result", result, 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Reset in the middle of an SLL by 20, after five steps have been applied.
        applyStimulus(2'b00, 32'h0000_0001, 5'd20);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("midShift_result", result, 32'h0000_0020);
        checkOutput("midShift_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midReset_result", result, 32'h0);
        checkOutput("midReset_busy", 32'(busy), 32'd0);
        checkOutput("midReset_done", 32'(done), 32'd0);
        reset = 1'b0;

        runOp("sll4", 2'b00, 32'h0000_0001, 5'd4, 32'h0000_0010);
        runOp("sra31", 2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF);
        runOp("srl31", 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001);
        runOp("ror4", 2'b11, 32'h0000_00F1, 5'd4, 32'h1000_000F);
        runOp("srl0", 2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF);
        runOp("sraPos", 2'b10, 32'h7000_0000, 5'd4, 32'h0700_0000);
        runOp("ror1", 2'b11, 32'h8000_0001, 5'd1, 32'hC000_0000);

        // Start held high through an SLL by 3 while data_in keeps changing.
        applyStimulus(2'b00, 32'h0000_0005, 5'd3);
        doneCount = 0;
        doneCycle = 0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1 data_in = 32'hA5A5_0000 + 32'(c);
            @(negedge clk);
            if (done) begin
                doneCount++;
                doneCycle = c;
                checkOutput("hold_result", result, 32'h0000_0028);
            end
        end
        checkOutput("hold_doneCount", 32'(doneCount), 32'd1);
        checkOutput("hold_doneCycle", 32'(doneCycle), 32'd4);
        checkOutput("hold_idleBusy", 32'(busy), 32'd0);
        checkOutput("hold_idleResult", result, 32'h0000_0028);
        data_in      = 32'h0000_0003;
        shift_amount = 5'd0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("second_done", 32'(done), 32'd1);
        checkOutput("second_result", result, 32'h0000_0003);
        @(negedge clk);
        checkOutput("second_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
